// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle CPU control path: opcodes, FSM state
// encodings, instruction classes and the select codes driven onto the datapath.
package cpu_defs;

  localparam int OP_W    = 6;
  localparam int ALUOP_W = 3;

  // R-type
  localparam logic [OP_W-1:0] OP_ADD  = 6'b000000;
  localparam logic [OP_W-1:0] OP_SUB  = 6'b000001;
  localparam logic [OP_W-1:0] OP_OR   = 6'b010000;
  localparam logic [OP_W-1:0] OP_AND  = 6'b010001;
  localparam logic [OP_W-1:0] OP_SLT  = 6'b100110;
  localparam logic [OP_W-1:0] OP_SLL  = 6'b011000;
  // I-type
  localparam logic [OP_W-1:0] OP_ADDI = 6'b000010;
  localparam logic [OP_W-1:0] OP_ORI  = 6'b010010;
  // Memory
  localparam logic [OP_W-1:0] OP_SW   = 6'b110000;
  localparam logic [OP_W-1:0] OP_LW   = 6'b110001;
  // Control
  localparam logic [OP_W-1:0] OP_BEQ  = 6'b110100;
  localparam logic [OP_W-1:0] OP_J    = 6'b111000;
  localparam logic [OP_W-1:0] OP_JR   = 6'b111001;
  localparam logic [OP_W-1:0] OP_JAL  = 6'b111010;
  localparam logic [OP_W-1:0] OP_HALT = 6'b111111;

  // The encodings are visible on the State debug port, so they are fixed values.
  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU_R,
    CLS_ALU_I,
    CLS_LD,
    CLS_ST,
    CLS_BR,
    CLS_JMP,
    CLS_HALT,
    CLS_ILLEGAL
  } op_class_e;

  localparam logic [ALUOP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALUOP_W-1:0] ALU_SLL = 3'b010;
  localparam logic [ALUOP_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALUOP_W-1:0] ALU_AND = 3'b100;
  localparam logic [ALUOP_W-1:0] ALU_SLT = 3'b101;

  localparam logic [1:0] PC_SRC_NEXT   = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_REG    = 2'b11;

  localparam logic [1:0] REG_DST_RA = 2'b00;
  localparam logic [1:0] REG_DST_RT = 2'b01;
  localparam logic [1:0] REG_DST_RD = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_dec.sv
// Opcode decoder: classifies the instruction and supplies the ALU controls
// used during the execute states. Purely combinational.
module multicycle_ctrl_dec
  import cpu_defs::*;
#(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3
) (
  input  logic [OP_W-1:0]    opcode,
  output op_class_e          op_class,
  output logic               is_jr,
  output logic               is_jal,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               alu_src_a,
  output logic               alu_src_b,
  output logic               ext_sel
);

  // Sign extension is the default; only ori wants its immediate zero-extended.
  always_comb begin
    op_class  = CLS_ILLEGAL;
    is_jr     = 1'b0;
    is_jal    = 1'b0;
    alu_op    = ALU_ADD;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    ext_sel   = 1'b1;
    case (opcode)
      OP_ADD: op_class = CLS_ALU_R;
      OP_SUB: begin
        op_class = CLS_ALU_R;
        alu_op   = ALU_SUB;
      end
      OP_OR: begin
        op_class = CLS_ALU_R;
        alu_op   = ALU_OR;
      end
      OP_AND: begin
        op_class = CLS_ALU_R;
        alu_op   = ALU_AND;
      end
      OP_SLT: begin
        op_class = CLS_ALU_R;
        alu_op   = ALU_SLT;
      end
      OP_SLL: begin
        op_class  = CLS_ALU_R;
        alu_op    = ALU_SLL;
        alu_src_a = 1'b1;
      end
      OP_ADDI: begin
        op_class  = CLS_ALU_I;
        alu_src_b = 1'b1;
      end
      OP_ORI: begin
        op_class  = CLS_ALU_I;
        alu_op    = ALU_OR;
        alu_src_b = 1'b1;
        ext_sel   = 1'b0;
      end
      OP_SW: begin
        op_class  = CLS_ST;
        alu_src_b = 1'b1;
      end
      OP_LW: begin
        op_class  = CLS_LD;
        alu_src_b = 1'b1;
      end
      OP_BEQ: begin
        op_class = CLS_BR;
        alu_op   = ALU_SUB;
      end
      OP_J:   op_class = CLS_JMP;
      OP_JR: begin
        op_class = CLS_JMP;
        is_jr    = 1'b1;
      end
      OP_JAL: begin
        op_class = CLS_JMP;
        is_jal   = 1'b1;
      end
      OP_HALT: op_class = CLS_HALT;
      default: op_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle CPU. State moves on the CLK posedge; all
// outputs are decoded from the registered state and the IR opcode, so they hold
// steady across the high phase and the following low phase where the PC samples.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IF     | fetch: load IR from instruction memory
//   S_ID     | decode; jumps/illegal finish here, halt parks here
//   S_EXE_AL | ALU operation for R-type and immediate instructions
//   S_EXE_BR | beq compare, PC updated from the Zero flag
//   S_EXE_LS | address calculation for lw/sw
//   S_MEM    | data memory access (sw finishes here)
//   S_WB_AL  | write ALU result to rd/rt
//   S_WB_LD  | write loaded data to rt
module multicycle_ctrl
  import cpu_defs::*;
#(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [OP_W-1:0]    Opcode,
  input  logic               Zero,
  output logic               PCWre,
  output logic [1:0]         PCSrc,
  output logic               IRWre,
  output logic               InsMemRW,
  output logic               RegWre,
  output logic [1:0]         RegDst,
  output logic               WrRegDSrc,
  output logic               DBDataSrc,
  output logic               ALUSrcA,
  output logic               ALUSrcB,
  output logic               ExtSel,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               mRD,
  output logic               mWR,
  output logic               Halted,
  output logic [2:0]         State
);

  state_e                 state_q;
  state_e                 state_d;
  op_class_e              op_class;
  logic                   is_jr;
  logic                   is_jal;
  logic [ALUOP_W-1:0]     dec_alu_op;
  logic                   dec_alu_src_a;
  logic                   dec_alu_src_b;
  logic                   dec_ext_sel;

  multicycle_ctrl_dec #(
    .OP_W    (OP_W),
    .ALUOP_W (ALUOP_W)
  ) u_dec (
    .opcode    (Opcode),
    .op_class  (op_class),
    .is_jr     (is_jr),
    .is_jal    (is_jal),
    .alu_op    (dec_alu_op),
    .alu_src_a (dec_alu_src_a),
    .alu_src_b (dec_alu_src_b),
    .ext_sel   (dec_ext_sel)
  );

  // State register; reset parks the FSM in fetch, whose outputs write nothing.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= S_IF;
    else      state_q <= state_d;
  end

  // Next-state and per-state output table. PCWre is raised only in the last
  // state of each instruction so the PC advances exactly once per instruction.
  always_comb begin
    state_d   = state_q;
    PCWre     = 1'b0;
    PCSrc     = PC_SRC_NEXT;
    IRWre     = 1'b0;
    InsMemRW  = 1'b0;
    RegWre    = 1'b0;
    RegDst    = REG_DST_RA;
    WrRegDSrc = 1'b0;
    DBDataSrc = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ExtSel    = 1'b0;
    ALUOp     = ALU_ADD;
    mRD       = 1'b0;
    mWR       = 1'b0;
    Halted    = 1'b0;
    case (state_q)
      S_IF: begin
        IRWre    = 1'b1;
        InsMemRW = 1'b1;
        state_d  = S_ID;
      end
      S_ID: begin
        case (op_class)
          CLS_JMP: begin
            PCWre   = 1'b1;
            PCSrc   = is_jr ? PC_SRC_REG : PC_SRC_JUMP;
            if (is_jal) begin
              RegWre    = 1'b1;
              RegDst    = REG_DST_RA;
              WrRegDSrc = 1'b0;
            end
            state_d = S_IF;
          end
          CLS_BR:            state_d = S_EXE_BR;
          CLS_LD, CLS_ST:    state_d = S_EXE_LS;
          CLS_ALU_R,
          CLS_ALU_I:         state_d = S_EXE_AL;
          CLS_HALT: begin
            Halted  = 1'b1;
            state_d = S_ID;
          end
          default: begin
            // Unrecognised opcode retires as a NOP: just step the PC.
            PCWre   = 1'b1;
            PCSrc   = PC_SRC_NEXT;
            state_d = S_IF;
          end
        endcase
      end
      S_EXE_AL: begin
        ALUOp   = dec_alu_op;
        ALUSrcA = dec_alu_src_a;
        ALUSrcB = dec_alu_src_b;
        ExtSel  = dec_ext_sel;
        state_d = S_WB_AL;
      end
      S_EXE_BR: begin
        ALUOp   = ALU_SUB;
        ALUSrcA = dec_alu_src_a;
        ALUSrcB = dec_alu_src_b;
        ExtSel  = dec_ext_sel;
        PCWre   = 1'b1;
        PCSrc   = Zero ? PC_SRC_BRANCH : PC_SRC_NEXT;
        state_d = S_IF;
      end
      S_EXE_LS: begin
        ALUOp   = dec_alu_op;
        ALUSrcA = dec_alu_src_a;
        ALUSrcB = dec_alu_src_b;
        ExtSel  = dec_ext_sel;
        state_d = S_MEM;
      end
      S_MEM: begin
        if (op_class == CLS_LD) begin
          mRD     = 1'b1;
          state_d = S_WB_LD;
        end else begin
          mWR     = (op_class == CLS_ST);
          PCWre   = 1'b1;
          state_d = S_IF;
        end
      end
      S_WB_AL: begin
        RegWre    = 1'b1;
        WrRegDSrc = 1'b1;
        DBDataSrc = 1'b0;
        RegDst    = (op_class == CLS_ALU_R) ? REG_DST_RD : REG_DST_RT;
        PCWre     = 1'b1;
        state_d   = S_IF;
      end
      S_WB_LD: begin
        RegWre    = 1'b1;
        WrRegDSrc = 1'b1;
        DBDataSrc = 1'b1;
        RegDst    = REG_DST_RT;
        PCWre     = 1'b1;
        mRD       = 1'b1;
        state_d   = S_IF;
      end
      default: state_d = S_IF;
    endcase
  end

  assign State = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: the stimulus side drives instructions and pushes the
// per-cycle expected control word from an instruction-level model; a monitor
// compares the DUT outputs against that queue on every falling edge.
module tb_multicycle_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [5:0] Opcode = 6'd0;
  logic       Zero = 1'b0;
  logic       PCWre, IRWre, InsMemRW, RegWre, WrRegDSrc, DBDataSrc;
  logic       ALUSrcA, ALUSrcB, ExtSel, mRD, mWR, Halted;
  logic [1:0] PCSrc, RegDst;
  logic [2:0] ALUOp, State;

  multicycle_ctrl dut (
    .CLK       (CLK),
    .RST       (RST),
    .Opcode    (Opcode),
    .Zero      (Zero),
    .PCWre     (PCWre),
    .PCSrc     (PCSrc),
    .IRWre     (IRWre),
    .InsMemRW  (InsMemRW),
    .RegWre    (RegWre),
    .RegDst    (RegDst),
    .WrRegDSrc (WrRegDSrc),
    .DBDataSrc (DBDataSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ExtSel    (ExtSel),
    .ALUOp     (ALUOp),
    .mRD       (mRD),
    .mWR       (mWR),
    .Halted    (Halted),
    .State     (State)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [2:0] st;
    logic       pcwre;
    logic [1:0] pcsrc;
    logic       irwre;
    logic       insmemrw;
    logic       regwre;
    logic [1:0] regdst;
    logic       wrregdsrc;
    logic       dbdatasrc;
    logic       alusrca;
    logic       alusrcb;
    logic       extsel;
    logic [2:0] aluop;
    logic       mrd;
    logic       mwr;
    logic       halted;
  } row_t;

  row_t  exp_q[$];
  string tag_q[$];
  int    n_chk  = 0;
  int    n_pass = 0;

  logic [5:0] legal_ops [16] = '{6'b000000, 6'b000001, 6'b010000, 6'b010001,
                                 6'b100110, 6'b011000, 6'b000010, 6'b010010,
                                 6'b110000, 6'b110001, 6'b110100, 6'b111000,
                                 6'b111001, 6'b111010, 6'b111111, 6'b101010};

  function automatic row_t dut_row();
    return {State, PCWre, PCSrc, IRWre, InsMemRW, RegWre, RegDst, WrRegDSrc,
            DBDataSrc, ALUSrcA, ALUSrcB, ExtSel, ALUOp, mRD, mWR, Halted};
  endfunction

  task automatic check(input string name, input row_t act, input row_t exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %06h (state %b) expected %06h (state %b) at %0t",
                  name, act, act.st, exp, exp.st, $time);
  endtask

  // ---- reference model: what each instruction does, cycle by cycle ----
  function automatic bit is_rtype(logic [5:0] op);
    return op inside {6'b000000, 6'b000001, 6'b010000, 6'b010001, 6'b100110, 6'b011000};
  endfunction

  function automatic bit is_itype(logic [5:0] op);
    return op inside {6'b000010, 6'b010010};
  endfunction

  function automatic int n_cycles(logic [5:0] op);
    if (is_rtype(op) || is_itype(op)) return 4;
    if (op == 6'b110001) return 5;
    if (op == 6'b110000) return 4;
    if (op == 6'b110100) return 3;
    return 2;
  endfunction

  function automatic row_t model_row(logic [5:0] op, int step, logic z);
    row_t r = '0;
    if (step == 0) begin
      r.irwre = 1; r.insmemrw = 1;
      return r;
    end
    if (step == 1) begin
      r.st = 3'b001;
      case (op)
        6'b111000: begin r.pcwre = 1; r.pcsrc = 2'b10; end
        6'b111001: begin r.pcwre = 1; r.pcsrc = 2'b11; end
        6'b111010: begin r.pcwre = 1; r.pcsrc = 2'b10; r.regwre = 1; end
        6'b111111: r.halted = 1;
        default:
          if (!(is_rtype(op) || is_itype(op) || op inside {6'b110000, 6'b110001, 6'b110100}))
            r.pcwre = 1;
      endcase
      return r;
    end
    if (op == 6'b110100) begin
      r.st = 3'b101; r.aluop = 3'b001; r.extsel = 1; r.pcwre = 1;
      r.pcsrc = z ? 2'b01 : 2'b00;
      return r;
    end
    if (op == 6'b110000 || op == 6'b110001) begin
      case (step)
        2: begin r.st = 3'b010; r.alusrcb = 1; r.extsel = 1; end
        3: begin
          r.st = 3'b011;
          if (op == 6'b110000) begin r.mwr = 1; r.pcwre = 1; end
          else r.mrd = 1;
        end
        default: begin
          r.st = 3'b100; r.regwre = 1; r.wrregdsrc = 1; r.dbdatasrc = 1;
          r.regdst = 2'b01; r.pcwre = 1; r.mrd = 1;
        end
      endcase
      return r;
    end
    if (step == 2) begin
      r.st = 3'b110;
      r.extsel = (op != 6'b010010);
      case (op)
        6'b000001: r.aluop = 3'b001;
        6'b010000: r.aluop = 3'b011;
        6'b010001: r.aluop = 3'b100;
        6'b100110: r.aluop = 3'b101;
        6'b011000: begin r.aluop = 3'b010; r.alusrca = 1; end
        6'b000010: r.alusrcb = 1;
        6'b010010: begin r.aluop = 3'b011; r.alusrcb = 1; end
        default:   r.aluop = 3'b000;
      endcase
    end else begin
      r.st = 3'b111; r.regwre = 1; r.wrregdsrc = 1; r.pcwre = 1;
      r.regdst = is_rtype(op) ? 2'b10 : 2'b01;
    end
    return r;
  endfunction

  // ---- monitor ----
  always @(negedge CLK) begin
    row_t  e;
    string t;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, dut_row(), e);
    end
  end

  // ---- stimulus (entered and left at posedge+1) ----
  task automatic reset_hold();
    for (int i = 0; i < 2; i++) begin
      Opcode = 6'($urandom_range(0, 63));
      Zero   = 1'b1;
      exp_q.push_back(model_row(6'd0, 0, 1'b0));
      tag_q.push_back("in_reset");
      @(posedge CLK); #1;
    end
    RST = 1'b1;
  endtask

  task automatic run_instr(input logic [5:0] op, input int hold, input int rst_step);
    int n;
    int ms;
    n = (op == 6'b111111) ? 1 + hold : n_cycles(op);
    for (int s = 0; s < n; s++) begin
      ms = (op == 6'b111111 && s > 1) ? 1 : s;
      Opcode = op;
      Zero   = 1'($urandom_range(0, 1));
      exp_q.push_back(model_row(op, ms, Zero));
      tag_q.push_back($sformatf("op%b_step%0d", op, s));
      if (s == rst_step) begin
        #5 RST = 1'b0;
        #1 check($sformatf("async_reset_op%b", op), dut_row(), model_row(op, 0, 1'b0));
        @(posedge CLK); #1;
        reset_hold();
        return;
      end
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    logic [5:0] op;
    int         hold;
    int         rst_step;
    @(posedge CLK); #1;
    reset_hold();
    run_instr(6'b000000, 0, -1);   // add
    run_instr(6'b110001, 0, -1);   // lw
    run_instr(6'b110000, 0, -1);   // sw
    run_instr(6'b110100, 0, -1);   // beq
    run_instr(6'b110100, 0, -1);
    run_instr(6'b111010, 0, -1);   // jal
    run_instr(6'b111001, 0, -1);   // jr
    run_instr(6'b111000, 0, -1);   // j
    run_instr(6'b101010, 0, -1);   // illegal -> NOP
    run_instr(6'b011000, 0, -1);   // sll
    run_instr(6'b010010, 0, -1);   // ori
    run_instr(6'b110001, 0, 3);    // reset while lw is in sMEM
    run_instr(6'b000010, 0, -1);   // addi after reset
    run_instr(6'b111111, 22, 22);  // halt held, then reset
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) < 7) op = legal_ops[$urandom_range(0, 15)];
      else                          op = 6'($urandom_range(0, 63));
      hold = 0;
      rst_step = -1;
      if (op == 6'b111111) begin
        hold = $urandom_range(2, 6);
        rst_step = hold;
      end else if ($urandom_range(0, 9) == 0) begin
        rst_step = $urandom_range(0, n_cycles(op) - 1);
      end
      run_instr(op, hold, rst_step);
    end
    @(negedge CLK); #1;
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL queue_drained: %0d rows left, expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1, "timeout");
  end

endmodule
